// File: rtl/serializer_4_1.sv
// 32-bit to 8-bit width converter with valid/ready handshakes on both sides.
// Emits four bytes per accepted word, MSB-first by default, with zero-bubble word chaining.
module serializer_4_1 #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  data_out,
    output logic [1:0]  col,
    output logic        last,
    output logic        busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [1:0] LAST_CNT = 2'd3;

    logic [0:0]  state_q, state_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] word_q,  word_d;

    logic        in_xfer;
    logic        out_xfer;
    logic        cnt_is_last;
    logic [1:0]  byte_slot;
    logic [7:0]  sel_byte;

    assign cnt_is_last = (cnt_q == LAST_CNT);

    // in_ready looks only at state, cnt and out_ready, never at in_valid,
    // so upstream may legally wait for ready before raising valid.
    always_comb begin
        in_ready = 1'b0;
        if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else if (cnt_is_last && out_ready) begin
            in_ready = 1'b1;
        end
    end

    assign in_xfer  = in_valid  && in_ready;
    assign out_xfer = out_valid && out_ready;

    // NOTE: every variable assigned here gets a default first so that no
    // path through the case leaves it unassigned (that would infer a latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    word_d  = data_in;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (out_xfer) begin
                    if (!cnt_is_last) begin
                        cnt_d = cnt_q + 2'd1;
                    end else if (in_xfer) begin
                        word_d  = data_in;
                        cnt_d   = 2'd0;
                        state_d = SEND;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            word_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // byte_slot counts byte lanes from bit 0; MSB-first order walks it downward.
    assign byte_slot = LSB_FIRST ? cnt_q : (LAST_CNT - cnt_q);

    always_comb begin
        sel_byte = 8'h00;
        case (byte_slot)
            2'd0:    sel_byte = word_q[7:0];
            2'd1:    sel_byte = word_q[15:8];
            2'd2:    sel_byte = word_q[23:16];
            default: sel_byte = word_q[31:24];
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        data_out  = 8'h00;
        col       = 2'd0;
        last      = 1'b0;
        busy      = 1'b0;
        if (state_q == SEND) begin
            out_valid = 1'b1;
            data_out  = sel_byte;
            col       = cnt_q;
            last      = cnt_is_last;
            busy      = 1'b1;
        end
    end

endmodule

// File: tb/tb_serializer_4_1.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share stimulus;
// a negedge monitor pops expected bytes whenever an output transfer is pending.
module tb_serializer_4_1;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] col;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] data_in;
    logic        out_ready;

    logic        in_ready0, out_valid0, last0, busy0;
    logic [7:0]  data_out0;
    logic [1:0]  col0;
    logic        in_ready1, out_valid1, last1, busy1;
    logic [7:0]  data_out1;
    logic [1:0]  col1;

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];

    serializer_4_1 #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .data_in(data_in), .out_valid(out_valid0), .out_ready(out_ready),
        .data_out(data_out0), .col(col0), .last(last0), .busy(busy0)
    );

    serializer_4_1 #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .data_in(data_in), .out_valid(out_valid1), .out_ready(out_ready),
        .data_out(data_out1), .col(col1), .last(last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] msb_sh;
            logic [31:0] lsb_sh;
            msb_sh = w >> (24 - 8 * k);
            lsb_sh = w >> (8 * k);
            q0.push_back('{data: msb_sh[7:0], col: k[1:0], last: (k == 3)});
            q1.push_back('{data: lsb_sh[7:0], col: k[1:0], last: (k == 3)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a word and waits for its acceptance edge; returns 1 ns after it
    // with in_valid still high.
    task automatic send_word(input logic [31:0] w);
        bit accepted;
        accepted = 1'b0;
        push_word(w);
        in_valid = 1'b1;
        data_in  = w;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready0) accepted = 1'b1;
        end
        if (!accepted) check("accept timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_col(input logic [1:0] c);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (busy0 && col0 == c) seen = 1'b1;
            else tick();
        end
        if (!seen) check("col wait timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, {31'd0, out_valid0}, 32'd0);
        check({tag, " data_out"},  {24'd0, data_out0},  32'd0);
        check({tag, " col"},       {30'd0, col0},       32'd0);
        check({tag, " last"},      {31'd0, last0},      32'd0);
        check({tag, " busy"},      {31'd0, busy0},      32'd0);
        check({tag, " in_ready"},  {31'd0, in_ready0},  32'd1);
        check({tag, " lsb busy"},  {31'd0, busy1},      32'd0);
    endtask

    // Monitor: a transfer will occur at the next rising edge whenever
    // out_valid && out_ready hold at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (out_valid0) begin
                if (q0.size() == 0) begin
                    check("msb unexpected byte", {24'd0, data_out0}, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("msb data", {24'd0, data_out0}, {24'd0, e.data});
                    check("msb col",  {30'd0, col0},      {30'd0, e.col});
                    check("msb last", {31'd0, last0},     {31'd0, e.last});
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    check("lsb unexpected byte", {24'd0, data_out1}, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("lsb data", {24'd0, data_out1}, {24'd0, e.data});
                    check("lsb col",  {30'd0, col1},      {30'd0, e.col});
                    check("lsb last", {31'd0, last1},     {31'd0, e.last});
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = 32'h9999_9999;
        out_ready = 1'b1;

        // Reset state is visible while rst is still high.
        #3;
        check_idle("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle("after reset");

        // Single word, both byte orders, exactly four output cycles.
        send_word(32'hA1B2C3D4);
        in_valid = 1'b0;
        check("first byte latency", {31'd0, out_valid0}, 32'd1);
        check("first byte hand msb", {24'd0, data_out0}, 32'h0000_00A1);
        check("first byte hand lsb", {24'd0, data_out1}, 32'h0000_00D4);
        for (int i = 0; i < 4; i++) tick();
        check_idle("after single word");
        check("single word drained", q0.size() + q1.size(), 32'd0);

        // Downstream stall on col=1 holds the byte and blocks input.
        send_word(32'hA1B2C3D4);
        in_valid = 1'b0;
        wait_col(2'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall msb data", {24'd0, data_out0}, 32'h0000_00B2);
            check("stall lsb data", {24'd0, data_out1}, 32'h0000_00C3);
            check("stall col",      {30'd0, col0},      32'd1);
            check("stall in_ready", {31'd0, in_ready0}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("stall resume col", {30'd0, col0}, 32'd1);
        tick();
        check("resume msb data", {24'd0, data_out0}, 32'h0000_00C3);
        tick();
        tick();
        check_idle("after stall");

        // Back-to-back words with in_valid held high: no bubble between them.
        push_word(32'h11223344);
        in_valid = 1'b1;
        data_in  = 32'h11223344;
        @(negedge clk);
        check("b2b first ready", {31'd0, in_ready0}, 32'd1);
        tick();
        push_word(32'h55667788);
        data_in = 32'h55667788;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp_col;
            exp_col = i[1:0];
            check("b2b busy",     {31'd0, busy0},     32'd1);
            check("b2b col",      {30'd0, col0},      {30'd0, exp_col});
            check("b2b in_ready", {31'd0, in_ready0}, {31'd0, (exp_col == 2'd3)});
            tick();
            if (i == 3) in_valid = 1'b0;
        end
        check_idle("after b2b");

        // A word offered mid-emission is ignored.
        send_word(32'h0A0B0C0D);
        in_valid = 1'b0;
        wait_col(2'd1);
        in_valid = 1'b1;
        data_in  = 32'hFFFFFFFF;
        #1;
        check("ignore in_ready", {31'd0, in_ready0}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("ignore msb data", {24'd0, data_out0}, 32'h0000_000C);
        tick();
        tick();
        check_idle("after ignore");

        // Reset mid-word discards the remaining bytes.
        send_word(32'h01020304);
        in_valid = 1'b0;
        wait_col(2'd2);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_idle("mid-word reset");
        q0.delete();
        q1.delete();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check_idle("post abort");
        send_word(32'hDEADBEEF);
        in_valid = 1'b0;
        check("deadbeef first", {24'd0, data_out0}, 32'h0000_00DE);
        for (int i = 0; i < 4; i++) tick();
        check_idle("after deadbeef");

        tick();
        check("scoreboard empty msb", q0.size(), 32'd0);
        check("scoreboard empty lsb", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serializer_4_1.md
SERIALIZER_4_1 -- requirements
Module: serializer_4_1

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 0, selecting byte order: 0 = bits [31:24] first, 1 = bits [7:0] first.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the upstream word on data_in is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts data_in this cycle.
REQ-006 The block SHALL have port data_in, input, 32, the packed word; byte k occupies bits [31-8k:24-8k].
REQ-007 The block SHALL have port out_valid, output, 1, meaning data_out holds a valid byte.
REQ-008 The block SHALL have port out_ready, input, 1, meaning downstream accepts the byte this cycle.
REQ-009 The block SHALL have port data_out, output, 8, the current byte.
REQ-010 The block SHALL have port col, output, 2, the byte index within the word of the current byte (0..3).
REQ-011 The block SHALL have port last, output, 1, asserted on the final byte of a word.
REQ-012 The block SHALL have port busy, output, 1, asserted while a word is being emitted.

Function
REQ-013 The block SHALL implement two states, IDLE and SEND, plus a word register (32 b) and a byte counter cnt (2 b).
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-015 in_ready SHALL be 1 in IDLE, and SHALL be 1 in SEND only when cnt==3 and out_ready==1; in_ready SHALL be 0 otherwise.
REQ-016 in_ready SHALL depend combinationally on out_ready and state only; it SHALL NOT depend on in_valid.
REQ-017 On an input transfer, the block SHALL capture data_in into the word register, set cnt=0, and be in SEND on the next cycle, giving 1-cycle latency from acceptance to out_valid.
REQ-018 In SEND, out_valid SHALL be 1, col SHALL equal cnt, and last SHALL equal (cnt==3).
REQ-019 In SEND with LSB_FIRST=0, data_out SHALL be byte cnt, i.e. bits [31-8*cnt:24-8*cnt]; with LSB_FIRST=1 it SHALL be byte (3-cnt), i.e. bits [8*cnt+7:8*cnt], while col still reports cnt.
REQ-020 In IDLE, out_valid, last and col SHALL be 0, and data_out SHALL be 8'h00.
REQ-021 On an output transfer with cnt<3, cnt SHALL increment by 1 and the state SHALL remain SEND.
REQ-022 On an output transfer with cnt==3 and a simultaneous input transfer, the block SHALL load the new word, set cnt=0 and remain in SEND, with no idle cycle between words.
REQ-023 On an output transfer with cnt==3 and no input transfer, the block SHALL return to IDLE.
REQ-024 While out_valid=1 and out_ready=0, data_out, col, last and the word register SHALL be held unchanged.
REQ-025 In SEND with cnt<3, in_valid SHALL be ignored, and the word register SHALL NOT change.
REQ-026 busy SHALL be 1 exactly when the state is SEND.
REQ-027 cnt SHALL never wrap except through REQ-022 or REQ-023; exactly 4 output transfers SHALL be produced per accepted word.

Reset
REQ-028 While rst=1, the block SHALL force state=IDLE, cnt=0 and word=32'h0, and immediately drive out_valid=0, data_out=8'h00, col=0, last=0, busy=0 and in_ready=1.
REQ-029 Assertion of rst mid-word SHALL discard the partial word; no remaining bytes SHALL be emitted after release.
REQ-030 After rst deasserts, the block SHALL accept a word on the first rising edge with in_valid=1.

Verification
REQ-031 The bench SHALL cover: in_valid=1 with data_in=32'hA1B2C3D4, out_ready held at 1, LSB_FIRST=0 -> data_out A1,B2,C3,D4 on 4 consecutive cycles, col 0..3, last only on D4, then IDLE.
REQ-032 The bench SHALL cover: the same word with LSB_FIRST=1 -> data_out D4,C3,B2,A1, col 0..3.
REQ-033 The bench SHALL cover: out_ready=0 for 3 cycles while col=1 -> data_out=B2 and col=1 stable throughout, in_ready=0, then the sequence resumes with C3.
REQ-034 The bench SHALL cover: back-to-back words 32'h11223344 and 32'h55667788 with in_valid held at 1 -> 8 contiguous bytes 11..88, in_ready=1 only on the cycle col=3, busy never dropping.
REQ-035 The bench SHALL cover: rst pulsed while col=2 -> outputs immediately 0 and in_ready=1; a new word 32'hDEADBEEF then emits DE,AD,BE,EF with nothing from the aborted word.
REQ-036 The bench SHALL cover: in_valid pulsed with 32'hFFFFFFFF while col=1 -> ignored, and the current word completes unchanged.
